regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the MIPS datapath. It replaces the fixed
//  2-read/1-write 32x32 file, which had no reset.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_init_ctrl.sv | 49 ++++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, limits and helpers for the multi-port register file.
package regfile_pkg;

   typedef enum logic {RF_INIT, RF_READY} rf_state_t;

   localparam int RF_MAX_RD = 4;
   localparam int RF_MAX_WR = 2;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_init_ctrl.sv
// regfile_init_ctrl: post-reset sweep FSM that clears one entry per cycle,
// then holds READY until the next reset.
module regfile_init_ctrl
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   rf_state_t         state, state_next;
   logic [ADDR_W-1:0] init_ptr, init_ptr_next;

   // NOTE: state registers use non-blocking assignments; the comb block computes next values with blocking ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RF_INIT;
         init_ptr <= '0;
      end else begin
         state    <= state_next;
         init_ptr <= init_ptr_next;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_next    = state;
      init_ptr_next = init_ptr;
      init_we       = 1'b0;
      ready         = 1'b0;
      if (state == RF_INIT) begin
         init_we       = 1'b1;
         init_ptr_next = init_ptr + ADDR_W'(1);
         if (init_ptr == LAST_ADDR) state_next = RF_READY;
      end else begin
         ready = 1'b1;
      end
   end

   assign init_addr = init_ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a post-reset clearing sweep.
// Define REGFILE_BYPASS_EN to forward same-edge write data to colliding reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int  DATA_W   = 32,
   parameter int  DEPTH    = 32,
   parameter int  NUM_RD   = 2,
   parameter int  NUM_WR   = 1,
   parameter int  ZERO_REG = 1,
   localparam int ADDR_W   = addr_w(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     ready,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data
);

   if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD out of range");
   end
   if (NUM_WR < 1 || NUM_WR > RF_MAX_WR) begin : g_bad_num_wr
      $error("regfile_mp: NUM_WR out of range");
   end
   if (DEPTH < 4 || (1 << ADDR_W) != DEPTH) begin : g_bad_depth
      $error("regfile_mp: DEPTH must be a power of two >= 4");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] ra [NUM_RD];
   logic [DATA_W-1:0] rd_next [NUM_RD];
   logic [DATA_W-1:0] rd_q [NUM_RD];
   logic [ADDR_W-1:0] wa [NUM_WR];
   logic [DATA_W-1:0] wd [NUM_WR];
   logic [NUM_WR-1:0] wr_ok;

   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_data;

   regfile_init_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_init_ctrl (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      assign ra[i]                       = rd_addr[i*ADDR_W +: ADDR_W];
      assign rd_data[i*DATA_W +: DATA_W] = rd_q[i];
   end

   // A user write counts only in READY and never to a hardwired zero entry.
   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
      assign wa[j]    = wr_addr[j*ADDR_W +: ADDR_W];
      assign wd[j]    = wr_data[j*DATA_W +: DATA_W];
      assign wr_ok[j] = we[j] && ready && !rst && !((ZERO_REG != 0) && (wa[j] == '0));
   end

   assign p0_we   = init_we | wr_ok[0];
   assign p0_addr = init_we ? init_addr : wa[0];
   assign p0_data = init_we ? '0 : wd[0];

   // NOTE: the array has no reset; the init sweep clears it, keeping it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (p0_we) mem[p0_addr] <= p0_data;
      // Higher-numbered ports are assigned later, so port 1 wins on an address clash.
      for (int j = 1; j < NUM_WR; j++) begin
         if (wr_ok[j]) mem[wa[j]] <= wd[j];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_next[i] = mem[ra[i]];
`ifdef REGFILE_BYPASS_EN
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j] && (wa[j] == ra[i])) rd_next[i] = wd[j];
         end
`endif
         if ((ZERO_REG != 0) && (ra[i] == '0)) rd_next[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RD; i++) begin
         if (rst || !ready) rd_q[i] <= '0;
         else               rd_q[i] <= rd_next[i];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (2R/2W with zero reg, plus a 1R/1W non-zero-reg instance).
module tb_regfile_mp;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  we;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;

   logic        ready_z;
   logic [4:0]  rd_addr_z;
   logic [31:0] rd_data_z;
   logic [0:0]  we_z;
   logic [4:0]  wr_addr_z;
   logic [31:0] wr_data_z;

   logic [31:0] model [32];
   exp_t        sb [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .we(we), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   regfile_mp #(
      .DATA_W(32), .DEPTH(32), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)
   ) dut_z (
      .clk(clk), .rst(rst), .ready(ready_z),
      .rd_addr(rd_addr_z), .rd_data(rd_data_z),
      .we(we_z), .wr_addr(wr_addr_z), .wr_data(wr_data_z)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] expect_read(input logic [4:0] ra, input logic [1:0] w,
                                               input logic [4:0] a0, input logic [31:0] d0,
                                               input logic [4:0] a1, input logic [31:0] d1);
      logic [31:0] v;
      if (ra == 5'd0) return 32'h0;
      v = model[ra];
`ifdef REGFILE_BYPASS_EN
      if (w[0] && a0 == ra) v = d0;
      if (w[1] && a1 == ra) v = d1;
`endif
      return v;
   endfunction

   // One READY-state cycle: drive writes and reads, queue expected read data, compare after the edge.
   task automatic step(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] ra0, input logic [4:0] ra1, input string name);
      exp_t e;
      we      = w;
      wr_addr = {a1, a0};
      wr_data = {d1, d0};
      rd_addr = {ra1, ra0};
      e.d0    = expect_read(ra0, w, a0, d0, a1, d1);
      e.d1    = expect_read(ra1, w, a0, d0, a1, d1);
      e.name  = name;
      sb.push_back(e);
      if (w[0] && a0 != 5'd0) model[a0] = d0;
      if (w[1] && a1 != 5'd0) model[a1] = d1;
      cycle();
      we = 2'b00;
      e  = sb.pop_front();
      n_tests++;
      if (rd_data[31:0] !== e.d0) begin
         n_fail++;
         $display("FAIL %s rd0 addr %0d: got %h expected %h", e.name, ra0, rd_data[31:0], e.d0);
      end
      n_tests++;
      if (rd_data[63:32] !== e.d1) begin
         n_fail++;
         $display("FAIL %s rd1 addr %0d: got %h expected %h", e.name, ra1, rd_data[63:32], e.d1);
      end
      n_tests++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready: got %b expected 1", e.name, ready);
      end
   endtask

   task automatic read_all(input string name);
      for (int a = 0; a < 32; a++) step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(a), 5'(31 - a), name);
   endtask

   // Counts INIT cycles after rst deasserts; ready must rise after exactly 32 of them.
   task automatic sweep_watch(input string name);
      for (int k = 1; k <= 34; k++) begin
         cycle();
         n_tests++;
         if (ready !== (k >= 32)) begin
            n_fail++;
            $display("FAIL %s ready cycle %0d: got %b expected %b", name, k, ready, (k >= 32));
         end
         n_tests++;
         if (rd_data !== 64'h0) begin
            n_fail++;
            $display("FAIL %s rd_data cycle %0d: got %h expected 0", name, k, rd_data);
         end
         if (k == 32) wr_addr[9:5] = 5'd0;
      end
   endtask

   task automatic test_reset();
      for (int a = 0; a < 32; a++) model[a] = 32'h0;
      rst     = 1'b1;
      we      = 2'b11;
      wr_addr = {5'd5, 5'd0};
      wr_data = {32'hBAD0_0001, 32'hBAD0_0000};
      rd_addr = {5'd5, 5'd3};
      cycle();
      n_tests++;
      if (ready !== 1'b0 || rd_data !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_state: got ready=%b rd_data=%h expected ready=0 rd_data=0", ready, rd_data);
      end
      rst = 1'b0;
      // Port 1 targets entry 5 only while INIT lasts, then only the dropped entry 0.
      sweep_watch("init_sweep");
      we = 2'b00;
      read_all("post_init_read");
   endtask

   task automatic test_basic_rw();
      step(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd1, 5'd2, "wr5");
      step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");
      n_tests++;
      if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL basic_rw_const: got %h expected deadbeefdeadbeef", rd_data);
      end
   endtask

   task automatic test_zero_reg();
      step(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd1, 5'd1, "wr0");
      step(2'b11, 5'd0, 32'h5555, 5'd0, 32'h6666, 5'd0, 5'd0, "wr0_rd0_same_edge");
      step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, "rd0");
      n_tests++;
      if (rd_data !== 64'h0) begin
         n_fail++;
         $display("FAIL zero_reg_const: got %h expected 0", rd_data);
      end
      we_z      = 1'b1;
      wr_addr_z = 5'd0;
      wr_data_z = 32'h1234;
      rd_addr_z = 5'd0;
      cycle();
      we_z = 1'b0;
      cycle();
      n_tests++;
      if (rd_data_z !== 32'h1234 || ready_z !== 1'b1) begin
         n_fail++;
         $display("FAIL no_zero_reg: got %h ready %b expected 00001234 ready 1", rd_data_z, ready_z);
      end
   endtask

   task automatic test_collision();
      logic [31:0] exp_coll;
`ifdef REGFILE_BYPASS_EN
      exp_coll = 32'h22;
`else
      exp_coll = 32'h11;
`endif
      step(2'b01, 5'd7, 32'h11, 5'd0, 32'h0, 5'd1, 5'd1, "wr7");
      step(2'b01, 5'd7, 32'h22, 5'd0, 32'h0, 5'd7, 5'd7, "collide7");
      n_tests++;
      if (rd_data[31:0] !== exp_coll) begin
         n_fail++;
         $display("FAIL collision_const: got %h expected %h", rd_data[31:0], exp_coll);
      end
      step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, "after_collide7");
   endtask

   task automatic test_dual_write();
      step(2'b11, 5'd9, 32'hAA, 5'd9, 32'hBB, 5'd9, 5'd9, "dual9");
      step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, "rd9");
      n_tests++;
      if (rd_data !== {32'hBB, 32'hBB}) begin
         n_fail++;
         $display("FAIL dual_write_const: got %h expected bb in both ports", rd_data);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "random");
      end
   endtask

   task automatic test_mid_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cycle();
         n_tests++;
         if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_first_sweep cycle %0d: got ready %b expected 0", k, ready);
         end
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int a = 0; a < 32; a++) model[a] = 32'h0;
      sweep_watch("restart_sweep");
      read_all("post_restart_read");
   endtask

   initial begin
      rst       = 1'b1;
      we        = 2'b00;
      wr_addr   = '0;
      wr_data   = '0;
      rd_addr   = '0;
      we_z      = 1'b0;
      wr_addr_z = '0;
      wr_data_z = '0;
      rd_addr_z = '0;
      test_reset();
      test_basic_rw();
      test_zero_reg();
      test_collision();
      test_dual_write();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
